// File: rtl/nac_sram.sv
`default_nettype none
// ============================================================================
// Module   : nac_sram
// Purpose  : Static-model binary arithmetic encoder; cumulative frequencies
//            are fetched from an external synchronous SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module nac_sram (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [8:0]  raw_data_i,
  input  logic        raw_data_vld_i,
  input  logic [31:0] mem_rd_data_i,
  input  logic        mem_stall_i,
  input  logic        encode_start_i,
  input  logic        encode_end_i,
  output logic        mem_rd_en_o,
  output logic [7:0]  mem_addr_o,
  output logic [7:0]  comp_data_o,
  output logic        comp_data_vld_o,
  output logic        nac_ready_o
);

  localparam logic [16:0] c_IDLE        = 17'h00001;
  localparam logic [16:0] c_CAL_RANGE   = 17'h00002;
  localparam logic [16:0] c_RD_CHECK    = 17'h00004;
  localparam logic [16:0] c_RD_MEM_HL   = 17'h00008;
  localparam logic [16:0] c_RD_MEM_L    = 17'h00010;
  localparam logic [16:0] c_RD_MEM_H    = 17'h00020;
  localparam logic [16:0] c_CAL_MUL     = 17'h00040;
  localparam logic [16:0] c_MUL_DELAY   = 17'h00080;
  localparam logic [16:0] c_CAL_DIV     = 17'h00100;
  localparam logic [16:0] c_DIV_DELAY   = 17'h00200;
  localparam logic [16:0] c_CAL_HL      = 17'h00400;
  localparam logic [16:0] c_RESCALE     = 17'h00800;
  localparam logic [16:0] c_OUTPUT_1    = 17'h01000;
  localparam logic [16:0] c_OUTPUT_0    = 17'h02000;
  localparam logic [16:0] c_OUTPUT_HOLD = 17'h04000;
  localparam logic [16:0] c_EOF_CHECK   = 17'h08000;
  localparam logic [16:0] c_FINISH      = 17'h10000;
  localparam logic [8:0]  c_EOF_SYM     = 9'd256;

  logic [16:0] r_state, w_next;
  logic        r_active, r_t_req, r_t_wait, r_ready, r_flush, r_first, r_more, r_out_one;
  logic [8:0]  r_sym;
  logic [15:0] r_total, r_low, r_high, r_pending, r_low_cum, r_high_cum;
  logic [16:0] r_range, r_rem_l, r_rem_h;
  logic [32:0] r_prod_l, r_prod_h;
  logic [5:0]  r_div_cnt;
  logic [1:0]  r_step;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_shift;

  logic        w_accept, w_out0, w_out1, w_e3, w_bit, w_done, w_ge_l, w_ge_h, w_unused;
  logic [16:0] w_rsh_l, w_rsh_h;

  assign w_accept = r_ready & (raw_data_vld_i | encode_end_i);
  assign w_out0   = r_high < 16'h8000;
  assign w_out1   = r_low >= 16'h8000;
  assign w_e3     = (r_low >= 16'h4000) && (r_high < 16'hC000);
  // First bit of a run is b, the pending follow-on bits are ~b
  assign w_bit    = r_first ? r_out_one : ~r_out_one;
  assign w_done   = r_first ? (r_pending == 16'd0) : (r_pending == 16'd1);
  // Restoring divider step, one quotient bit per cycle for both bounds
  assign w_rsh_l  = {r_rem_l[15:0], r_prod_l[32]};
  assign w_rsh_h  = {r_rem_h[15:0], r_prod_h[32]};
  assign w_ge_l   = w_rsh_l >= {1'b0, r_total};
  assign w_ge_h   = w_rsh_h >= {1'b0, r_total};
  assign w_unused = ^{mem_rd_data_i[31:16], r_rem_l[16], r_rem_h[16]};

  always_ff @(posedge clk_i or posedge reset_n_i) begin
    if (reset_n_i)         r_state <= c_IDLE;
    else if (!mem_stall_i) r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:      if (w_accept) w_next = c_CAL_RANGE;
      c_CAL_RANGE: w_next = c_RD_CHECK;
      c_RD_CHECK: begin
        if (r_sym == 9'd0)           w_next = c_RD_MEM_H;
        else if (r_sym == 9'd255)    w_next = c_RD_MEM_L;
        else if (r_sym == c_EOF_SYM) w_next = c_CAL_MUL;
        else                         w_next = c_RD_MEM_HL;
      end
      c_RD_MEM_HL: if (r_step == 2'd3) w_next = c_CAL_MUL;
      c_RD_MEM_L,
      c_RD_MEM_H:  if (r_step == 2'd1) w_next = c_CAL_MUL;
      c_CAL_MUL:   w_next = c_MUL_DELAY;
      c_MUL_DELAY: w_next = c_CAL_DIV;
      c_CAL_DIV:   w_next = c_DIV_DELAY;
      c_DIV_DELAY: if (r_div_cnt == 6'd32) w_next = c_CAL_HL;
      c_CAL_HL:    w_next = c_RESCALE;
      c_RESCALE: begin
        if (w_out0)      w_next = c_OUTPUT_0;
        else if (w_out1) w_next = c_OUTPUT_1;
        else if (!w_e3)  w_next = c_EOF_CHECK;
      end
      c_OUTPUT_1,
      c_OUTPUT_0: begin
        if (r_bitcnt == 3'd7) w_next = c_OUTPUT_HOLD;
        else if (w_done)      w_next = r_flush ? c_EOF_CHECK : c_RESCALE;
      end
      c_OUTPUT_HOLD: begin
        if (r_more)       w_next = r_out_one ? c_OUTPUT_1 : c_OUTPUT_0;
        else if (r_flush) w_next = c_EOF_CHECK;
        else              w_next = c_RESCALE;
      end
      c_EOF_CHECK: begin
        if (!r_flush) begin
          if (r_sym != c_EOF_SYM)      w_next = c_IDLE;
          else if (r_low < 16'h4000)   w_next = c_OUTPUT_0;
          else                         w_next = c_OUTPUT_1;
        end else if (r_bitcnt == 3'd0) w_next = c_FINISH;
        else if (r_bitcnt == 3'd7)     w_next = c_OUTPUT_HOLD;
      end
      c_FINISH: w_next = c_IDLE;
      default:  w_next = c_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en_o     = 1'b0;
    mem_addr_o      = 8'd0;
    comp_data_o     = 8'd0;
    comp_data_vld_o = 1'b0;
    nac_ready_o     = 1'b0;
    case (r_state)
      c_IDLE: begin
        mem_rd_en_o = r_t_req;
        nac_ready_o = r_ready;
      end
      c_RD_MEM_HL: begin
        mem_rd_en_o = ~r_step[0];
        mem_addr_o  = r_step[1] ? (r_sym[7:0] + 8'd1) : r_sym[7:0];
      end
      c_RD_MEM_L: begin
        mem_rd_en_o = ~r_step[0];
        mem_addr_o  = 8'd255;
      end
      c_RD_MEM_H: begin
        mem_rd_en_o = ~r_step[0];
        mem_addr_o  = 8'd1;
      end
      c_OUTPUT_HOLD: begin
        comp_data_o     = r_shift;
        comp_data_vld_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_n_i) begin
    if (reset_n_i) begin
      r_active <= 1'b0;  r_t_req <= 1'b0;  r_t_wait <= 1'b0;  r_ready <= 1'b0;
      r_flush  <= 1'b0;  r_first <= 1'b0;  r_more   <= 1'b0;  r_out_one <= 1'b0;
      r_sym    <= 9'd0;  r_total <= 16'd0; r_low    <= 16'd0; r_high <= 16'hFFFF;
      r_pending <= 16'd0; r_low_cum <= 16'd0; r_high_cum <= 16'd0;
      r_range  <= 17'd0; r_rem_l <= 17'd0; r_rem_h  <= 17'd0;
      r_prod_l <= 33'd0; r_prod_h <= 33'd0; r_div_cnt <= 6'd0;
      r_step   <= 2'd0;  r_bitcnt <= 3'd0; r_shift  <= 8'd0;
    end else if (!mem_stall_i) begin
      case (r_state)
        c_IDLE: begin
          if (!r_active && encode_start_i) begin
            r_active  <= 1'b1;
            r_t_req   <= 1'b1;
            r_flush   <= 1'b0;
            r_low     <= 16'd0;
            r_high    <= 16'hFFFF;
            r_pending <= 16'd0;
            r_bitcnt  <= 3'd0;
          end
          if (r_t_req) begin
            r_t_req  <= 1'b0;
            r_t_wait <= 1'b1;
          end
          if (r_t_wait) begin
            r_total  <= mem_rd_data_i[15:0];
            r_t_wait <= 1'b0;
            r_ready  <= 1'b1;
          end
          if (w_accept) begin
            r_ready <= 1'b0;
            r_sym   <= encode_end_i ? c_EOF_SYM : raw_data_i;
          end
        end
        c_CAL_RANGE: r_range <= {1'b0, r_high} - {1'b0, r_low} + 17'd1;
        c_RD_CHECK: begin
          r_step <= 2'd0;
          if (r_sym == 9'd0)    r_low_cum  <= 16'd0;
          if (r_sym == 9'd255)  r_high_cum <= r_total - 16'd1;
          if (r_sym == c_EOF_SYM) begin
            r_low_cum  <= r_total - 16'd1;
            r_high_cum <= r_total;
          end
        end
        c_RD_MEM_HL: begin
          r_step <= r_step + 2'd1;
          if (r_step == 2'd1) r_low_cum  <= mem_rd_data_i[15:0];
          if (r_step == 2'd3) r_high_cum <= mem_rd_data_i[15:0];
        end
        c_RD_MEM_L: begin
          r_step <= r_step + 2'd1;
          if (r_step == 2'd1) r_low_cum <= mem_rd_data_i[15:0];
        end
        c_RD_MEM_H: begin
          r_step <= r_step + 2'd1;
          if (r_step == 2'd1) r_high_cum <= mem_rd_data_i[15:0];
        end
        c_CAL_MUL: begin
          r_prod_h <= {16'd0, r_range} * {17'd0, r_high_cum};
          r_prod_l <= {16'd0, r_range} * {17'd0, r_low_cum};
        end
        c_CAL_DIV: begin
          r_rem_l   <= 17'd0;
          r_rem_h   <= 17'd0;
          r_div_cnt <= 6'd0;
        end
        c_DIV_DELAY: begin
          r_rem_l   <= w_ge_l ? (w_rsh_l - {1'b0, r_total}) : w_rsh_l;
          r_rem_h   <= w_ge_h ? (w_rsh_h - {1'b0, r_total}) : w_rsh_h;
          r_prod_l  <= {r_prod_l[31:0], w_ge_l};
          r_prod_h  <= {r_prod_h[31:0], w_ge_h};
          r_div_cnt <= r_div_cnt + 6'd1;
        end
        c_CAL_HL: begin
          r_high <= r_low + r_prod_h[15:0] - 16'd1;
          r_low  <= r_low + r_prod_l[15:0];
        end
        c_RESCALE: begin
          if (w_out0 || w_out1) begin
            // Subtracting 0x8000 before the shift is lost off the top anyway
            r_out_one <= ~w_out0;
            r_first   <= 1'b1;
            r_low     <= {r_low[14:0], 1'b0};
            r_high    <= {r_high[14:0], 1'b1};
          end else if (w_e3) begin
            r_pending <= r_pending + 16'd1;
            r_low     <= {1'b0, r_low[13:0], 1'b0};
            r_high    <= {1'b1, r_high[13:0], 1'b1};
          end
        end
        c_OUTPUT_1,
        c_OUTPUT_0: begin
          r_shift  <= {r_shift[6:0], w_bit};
          r_bitcnt <= r_bitcnt + 3'd1;
          r_more   <= ~w_done;
          if (r_first) r_first   <= 1'b0;
          else         r_pending <= r_pending - 16'd1;
        end
        c_EOF_CHECK: begin
          if (!r_flush) begin
            if (r_sym == c_EOF_SYM) begin
              r_flush   <= 1'b1;
              r_pending <= r_pending + 16'd1;
              r_out_one <= (r_low >= 16'h4000);
              r_first   <= 1'b1;
            end else begin
              r_ready <= 1'b1;
            end
          end else if (r_bitcnt != 3'd0) begin
            r_shift  <= {r_shift[6:0], 1'b0};
            r_bitcnt <= r_bitcnt + 3'd1;
            r_more   <= 1'b0;
          end
        end
        c_FINISH: begin
          r_ready  <= 1'b0;
          r_active <= 1'b0;
          r_flush  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nac_sram.sv
`default_nettype none
// ============================================================================
// Module   : tb_nac_sram
// Purpose  : Directed self-checking bench for the nac_sram encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nac_sram;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b1;
  logic [8:0]  raw_data_i = 9'd0;
  logic        raw_data_vld_i = 1'b0;
  logic [31:0] mem_rd_data_i = 32'd0;
  logic        mem_stall_i = 1'b0;
  logic        encode_start_i = 1'b0;
  logic        encode_end_i = 1'b0;
  logic        mem_rd_en_o;
  logic [7:0]  mem_addr_o;
  logic [7:0]  comp_data_o;
  logic        comp_data_vld_o;
  logic        nac_ready_o;

  logic [31:0] mem [0:255];
  logic [7:0]  q_bytes [$];
  logic [7:0]  q_reads [$];
  int          n_vec = 0;
  int          n_err = 0;

  nac_sram dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .raw_data_i(raw_data_i),
    .raw_data_vld_i(raw_data_vld_i), .mem_rd_data_i(mem_rd_data_i),
    .mem_stall_i(mem_stall_i), .encode_start_i(encode_start_i),
    .encode_end_i(encode_end_i), .mem_rd_en_o(mem_rd_en_o),
    .mem_addr_o(mem_addr_o), .comp_data_o(comp_data_o),
    .comp_data_vld_o(comp_data_vld_o), .nac_ready_o(nac_ready_o)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous SRAM: a request accepted on this edge returns data next cycle
  always @(posedge clk_i) begin
    if (mem_rd_en_o && !mem_stall_i) begin
      mem_rd_data_i <= mem[mem_addr_o];
      q_reads.push_back(mem_addr_o);
    end
  end

  always @(negedge clk_i) if (comp_data_vld_o) q_bytes.push_back(comp_data_o);

  function automatic string fmt(input logic [7:0] q [$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  task automatic start_stream();
    @(negedge clk_i); encode_start_i = 1'b1;
    @(negedge clk_i); encode_start_i = 1'b0;
  endtask

  task automatic send_sym(input logic [8:0] s, input logic use_end);
    int t = 0;
    while (!nac_ready_o && t < 300) begin @(negedge clk_i); t++; end
    n_vec++;
    if (!nac_ready_o) begin
      n_err++;
      $display("FAIL ready_timeout: nac_ready_o=%b after %0d cycles, want 1", nac_ready_o, t);
    end
    if (use_end) encode_end_i = 1'b1;
    else begin raw_data_i = s; raw_data_vld_i = 1'b1; end
    @(negedge clk_i);
    encode_end_i = 1'b0; raw_data_vld_i = 1'b0;
  endtask

  task automatic clear_logs();
    q_bytes.delete(); q_reads.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    n_vec++; if (mem_rd_en_o !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b want 0", mem_rd_en_o); end
    n_vec++; if (mem_addr_o !== 8'd0) begin n_err++; $display("FAIL reset_addr: got %h want 00", mem_addr_o); end
    n_vec++; if (comp_data_o !== 8'd0) begin n_err++; $display("FAIL reset_data: got %h want 00", comp_data_o); end
    n_vec++; if (comp_data_vld_o !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b want 0", comp_data_vld_o); end
    n_vec++; if (nac_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", nac_ready_o); end
    reset_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_eof_only();
    clear_logs();
    start_stream();
    send_sym(9'd256, 1'b0);
    repeat (150) @(negedge clk_i);
    n_vec++;
    if (q_bytes.size() != 1 || q_bytes[0] !== 8'hD0) begin
      n_err++; $display("FAIL eof_bytes: got %s want d0", fmt(q_bytes));
    end
    n_vec++;
    if (q_reads.size() != 1 || q_reads[0] !== 8'd0) begin
      n_err++; $display("FAIL eof_reads: got %s want 00", fmt(q_reads));
    end
  endtask

  task automatic test_sym0();
    clear_logs();
    start_stream();
    send_sym(9'd0, 1'b0);
    n_vec++;
    if (nac_ready_o !== 1'b0) begin n_err++; $display("FAIL sym0_ready_drop: got %b want 0", nac_ready_o); end
    send_sym(9'd256, 1'b0);
    repeat (150) @(negedge clk_i);
    n_vec++;
    if (q_bytes.size() != 1 || q_bytes[0] !== 8'h34) begin
      n_err++; $display("FAIL sym0_bytes: got %s want 34", fmt(q_bytes));
    end
    n_vec++;
    if (q_reads.size() != 2 || q_reads[0] !== 8'd0 || q_reads[1] !== 8'd1) begin
      n_err++; $display("FAIL sym0_reads: got %s want 00 01", fmt(q_reads));
    end
  endtask

  // Symbol 1 takes the E3 path; stray start/valid pulses mid-stream are ignored
  task automatic test_sym1();
    clear_logs();
    start_stream();
    send_sym(9'd1, 1'b0);
    encode_start_i = 1'b1; raw_data_i = 9'd5; raw_data_vld_i = 1'b1;
    repeat (3) @(negedge clk_i);
    encode_start_i = 1'b0; raw_data_vld_i = 1'b0;
    send_sym(9'd256, 1'b0);
    repeat (150) @(negedge clk_i);
    n_vec++;
    if (q_bytes.size() != 1 || q_bytes[0] !== 8'hA8) begin
      n_err++; $display("FAIL sym1_bytes: got %s want a8", fmt(q_bytes));
    end
    n_vec++;
    if (q_reads.size() != 3 || q_reads[0] !== 8'd0 || q_reads[1] !== 8'd1 || q_reads[2] !== 8'd2) begin
      n_err++; $display("FAIL sym1_reads: got %s want 00 01 02", fmt(q_reads));
    end
  endtask

  task automatic test_multi_byte();
    clear_logs();
    start_stream();
    for (int i = 0; i < 4; i++) send_sym(9'd0, 1'b0);
    send_sym(9'd256, 1'b0);
    repeat (150) @(negedge clk_i);
    n_vec++;
    if (q_bytes.size() != 2 || q_bytes[0] !== 8'h00 || q_bytes[1] !== 8'hD0) begin
      n_err++; $display("FAIL multi_bytes: got %s want 00 d0", fmt(q_bytes));
    end
    n_vec++;
    if (q_reads.size() != 5 || q_reads[4] !== 8'd1) begin
      n_err++; $display("FAIL multi_reads: got %s want 00 01 01 01 01", fmt(q_reads));
    end
  endtask

  task automatic test_sym255();
    mem[255] = 32'd2;
    clear_logs();
    start_stream();
    send_sym(9'd255, 1'b0);
    send_sym(9'd256, 1'b0);
    repeat (150) @(negedge clk_i);
    n_vec++;
    if (q_bytes.size() != 1 || q_bytes[0] !== 8'hB4) begin
      n_err++; $display("FAIL sym255_bytes: got %s want b4", fmt(q_bytes));
    end
    n_vec++;
    if (q_reads.size() != 2 || q_reads[1] !== 8'd255) begin
      n_err++; $display("FAIL sym255_reads: got %s want 00 ff", fmt(q_reads));
    end
    mem[255] = 32'd3;
  endtask

  task automatic test_stall();
    int t = 0;
    clear_logs();
    start_stream();
    send_sym(9'd1, 1'b0);
    while (!(mem_rd_en_o === 1'b1 && mem_addr_o === 8'd1) && t < 20) begin @(negedge clk_i); t++; end
    mem_stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      n_vec++;
      if (mem_rd_en_o !== 1'b1 || mem_addr_o !== 8'd1) begin
        n_err++; $display("FAIL stall_hold_%0d: rd_en=%b addr=%h want 1/01", i, mem_rd_en_o, mem_addr_o);
      end
    end
    mem_stall_i = 1'b0;
    send_sym(9'd256, 1'b0);
    repeat (150) @(negedge clk_i);
    n_vec++;
    if (q_bytes.size() != 1 || q_bytes[0] !== 8'hA8) begin
      n_err++; $display("FAIL stall_bytes: got %s want a8", fmt(q_bytes));
    end
    n_vec++;
    if (q_reads.size() != 3 || q_reads[1] !== 8'd1 || q_reads[2] !== 8'd2) begin
      n_err++; $display("FAIL stall_reads: got %s want 00 01 02", fmt(q_reads));
    end
  endtask

  task automatic test_encode_end();
    clear_logs();
    start_stream();
    send_sym(9'd0, 1'b1);
    repeat (150) @(negedge clk_i);
    n_vec++;
    if (q_bytes.size() != 1 || q_bytes[0] !== 8'hD0) begin
      n_err++; $display("FAIL end_bytes: got %s want d0", fmt(q_bytes));
    end
    n_vec++;
    if (nac_ready_o !== 1'b0) begin n_err++; $display("FAIL end_ready_after_finish: got %b want 0", nac_ready_o); end
    raw_data_i = 9'd256; raw_data_vld_i = 1'b1;
    repeat (3) @(negedge clk_i);
    raw_data_vld_i = 1'b0;
    repeat (100) @(negedge clk_i);
    n_vec++;
    if (q_bytes.size() != 1) begin
      n_err++; $display("FAIL end_ignore_vld: got %s want d0", fmt(q_bytes));
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    start_stream();
    send_sym(9'd256, 1'b0);
    repeat (15) @(negedge clk_i);
    reset_n_i = 1'b1;
    #1;
    n_vec++;
    if ({mem_rd_en_o, mem_addr_o, comp_data_o, comp_data_vld_o, nac_ready_o} !== 19'd0) begin
      n_err++; $display("FAIL midreset_outputs: got rd=%b a=%h d=%h v=%b r=%b want all 0",
                        mem_rd_en_o, mem_addr_o, comp_data_o, comp_data_vld_o, nac_ready_o);
    end
    repeat (3) @(negedge clk_i);
    reset_n_i = 1'b0;
    repeat (100) @(negedge clk_i);
    n_vec++;
    if (q_bytes.size() != 0) begin
      n_err++; $display("FAIL midreset_no_byte: got %s want none", fmt(q_bytes));
    end
    clear_logs();
    start_stream();
    send_sym(9'd256, 1'b0);
    repeat (150) @(negedge clk_i);
    n_vec++;
    if (q_bytes.size() != 1 || q_bytes[0] !== 8'hD0) begin
      n_err++; $display("FAIL midreset_restart_bytes: got %s want d0", fmt(q_bytes));
    end
  endtask

  initial begin
    mem[0] = 32'd4;
    mem[1] = 32'd1;
    for (int a = 2; a < 256; a++) mem[a] = 32'd3;
    test_reset();
    test_eof_only();
    test_sym0();
    test_sym1();
    test_multi_byte();
    test_sym255();
    test_stall();
    test_encode_end();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
